// File: rtl/extram_arbiter_if.sv
// -----------------------------------------------------------------------------
// extram_arbiter_if
//   Wishbone B4 classic, 8-bit data, single-beat bus between the CPU (master)
//   and the external SRAM arbiter (slave).
//
//   Handshake: the master raises I_wb_stb with I_wb_adr/I_wb_we/I_wb_dat
//   stable and holds all of them until it sees O_wb_ack high on a rising edge.
//   O_wb_ack is a single-cycle pulse; O_wb_dat is valid while O_wb_ack is high
//   on a read. The master must drop (or change) its request in the cycle that
//   follows the ack; a strobe still high while ack is high is ignored.
//
//   Signals:
//     I_wb_adr  [ADDR_WIDTH]  byte address
//     I_wb_dat  [8]           write data
//     I_wb_stb  [1]           strobe / request
//     I_wb_we   [1]           write enable
//     O_wb_ack  [1]           acknowledge pulse
//     O_wb_dat  [8]           read data
// -----------------------------------------------------------------------------
interface extram_arbiter_if #(
  parameter int ADDR_WIDTH = 19
);
  logic [ADDR_WIDTH-1:0] I_wb_adr;
  logic [7:0]            I_wb_dat;
  logic                  I_wb_stb;
  logic                  I_wb_we;
  logic                  O_wb_ack;
  logic [7:0]            O_wb_dat;

  modport master (
    output I_wb_adr, I_wb_dat, I_wb_stb, I_wb_we,
    input  O_wb_ack, O_wb_dat
  );

  modport slave (
    input  I_wb_adr, I_wb_dat, I_wb_stb, I_wb_we,
    output O_wb_ack, O_wb_dat
  );
endinterface

// File: rtl/extram_arbiter.sv
// -----------------------------------------------------------------------------
// extram_arbiter
//   Single-port owner of the external 8-bit asynchronous SRAM (512 KiB).
//   The VGA scanout read port has hard priority and a fixed 1-cycle latency;
//   the CPU Wishbone port is served in the remaining SRAM cycles.
//
//   Every SRAM operation lasts exactly one clock cycle. The FSM state names the
//   operation occupying the current SRAM cycle (IDLE, VGA_RD, WB_RD, WB_WR), and
//   all SRAM pins are registered from the next-state decision, so the pins
//   always match the state register.
//
//   Optional feature (macro EXTRAM_REQ_CHECK_EN):
//     defined   -> O_err is a sticky flag set when I_vga_req is high on two
//                  consecutive rising edges; cleared only by reset.
//     undefined -> O_err is tied to 0 and no checker logic exists.
//
//   Ports:
//     I_clk, I_reset_n     clock (rising edge) / async active-low reset
//     I_vga_req, I_vga_adr one-cycle VGA read request and its address
//     O_vga_dat            VGA read data (combinational from I_sram_dat)
//     wb                   Wishbone slave interface (extram_arbiter_if.slave)
//     O_sram_*             registered SRAM address/data/strobes
//     I_sram_dat           SRAM read data from the pad
//     O_err                VGA request-spacing violation flag
//     O_dbg_state          current FSM state (debug visibility)
// -----------------------------------------------------------------------------
module extram_arbiter #(
  parameter int ADDR_WIDTH = 19
) (
  input  logic                  I_clk,
  input  logic                  I_reset_n,

  input  logic                  I_vga_req,
  input  logic [ADDR_WIDTH-1:0] I_vga_adr,
  output logic [7:0]            O_vga_dat,

  extram_arbiter_if.slave       wb,

  output logic [ADDR_WIDTH-1:0] O_sram_adr,
  output logic [7:0]            O_sram_dat,
  input  logic [7:0]            I_sram_dat,
  output logic                  O_sram_dat_oe,
  output logic                  O_sram_ce_n,
  output logic                  O_sram_oe_n,
  output logic                  O_sram_we_n,

  output logic                  O_err,
  output logic [1:0]            O_dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VGA_RD = 2'd1,
    WB_RD  = 2'd2,
    WB_WR  = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] sram_adr_q, sram_adr_d;
  logic [7:0]            sram_dat_q, sram_dat_d;
  logic                  sram_dat_oe_q, sram_dat_oe_d;
  logic                  sram_ce_n_q, sram_ce_n_d;
  logic                  sram_oe_n_q, sram_oe_n_d;
  logic                  sram_we_n_q, sram_we_n_d;
  logic                  wb_ack_q, wb_ack_d;
  logic [7:0]            wb_dat_q, wb_dat_d;

  // Next-state decision and registered pin values for the cycle being entered.
  always_comb begin
    state_d       = IDLE;
    sram_adr_d    = sram_adr_q;
    sram_dat_d    = sram_dat_q;
    sram_dat_oe_d = 1'b0;
    sram_ce_n_d   = 1'b1;
    sram_oe_n_d   = 1'b1;
    sram_we_n_d   = 1'b1;

    // A Wishbone access is taken only once: not while its ack is out, and
    // not in the cycle right after it was served (the master still holds stb).
    if (I_vga_req) begin
      state_d = VGA_RD;
    end else if (wb.I_wb_stb && !wb_ack_q &&
                 (state_q != WB_RD) && (state_q != WB_WR)) begin
      state_d = wb.I_wb_we ? WB_WR : WB_RD;
    end

    case (state_d)
      VGA_RD: begin
        sram_adr_d  = I_vga_adr;
        sram_ce_n_d = 1'b0;
        sram_oe_n_d = 1'b0;
      end
      WB_RD: begin
        sram_adr_d  = wb.I_wb_adr;
        sram_ce_n_d = 1'b0;
        sram_oe_n_d = 1'b0;
      end
      WB_WR: begin
        sram_adr_d    = wb.I_wb_adr;
        sram_dat_d    = wb.I_wb_dat;
        sram_dat_oe_d = 1'b1;
        sram_ce_n_d   = 1'b0;
        sram_we_n_d   = 1'b0;
      end
      default: begin
      end
    endcase

    // The Wishbone operation completes at the edge that ends its SRAM cycle.
    wb_ack_d = (state_q == WB_RD) || (state_q == WB_WR);
    wb_dat_d = (state_q == WB_RD) ? I_sram_dat : wb_dat_q;
  end

  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      state_q       <= IDLE;
      sram_adr_q    <= '0;
      sram_dat_q    <= '0;
      sram_dat_oe_q <= 1'b0;
      sram_ce_n_q   <= 1'b1;
      sram_oe_n_q   <= 1'b1;
      sram_we_n_q   <= 1'b1;
      wb_ack_q      <= 1'b0;
      wb_dat_q      <= '0;
    end else begin
      state_q       <= state_d;
      sram_adr_q    <= sram_adr_d;
      sram_dat_q    <= sram_dat_d;
      sram_dat_oe_q <= sram_dat_oe_d;
      sram_ce_n_q   <= sram_ce_n_d;
      sram_oe_n_q   <= sram_oe_n_d;
      sram_we_n_q   <= sram_we_n_d;
      wb_ack_q      <= wb_ack_d;
      wb_dat_q      <= wb_dat_d;
    end
  end

`ifdef EXTRAM_REQ_CHECK_EN
  logic vga_req_prev_q, vga_req_prev_d;
  logic err_q, err_d;

  always_comb begin
    vga_req_prev_d = I_vga_req;
    err_d          = err_q | (I_vga_req & vga_req_prev_q);
  end

  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      vga_req_prev_q <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      vga_req_prev_q <= vga_req_prev_d;
      err_q          <= err_d;
    end
  end

  assign O_err = err_q;
`else
  assign O_err = 1'b0;
`endif

  // The VGA consumer samples the pad directly at the end of the VGA_RD cycle.
  assign O_vga_dat     = I_sram_dat;

  assign O_sram_adr    = sram_adr_q;
  assign O_sram_dat    = sram_dat_q;
  assign O_sram_dat_oe = sram_dat_oe_q;
  assign O_sram_ce_n   = sram_ce_n_q;
  assign O_sram_oe_n   = sram_oe_n_q;
  assign O_sram_we_n   = sram_we_n_q;
  assign wb.O_wb_ack   = wb_ack_q;
  assign wb.O_wb_dat   = wb_dat_q;
  assign O_dbg_state   = state_q;

endmodule
